// File: rtl/hazard_ctrl.sv
// Pipeline hazard and bypass controller: shadows EX/MEM/WB register-use fields
// and drives stall, bubble, flush and EX-operand forwarding selects.
module hazard_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             bypass_en,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [4:0]       id_rd,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             ex_branch_taken,
   output logic             pc_hold,
   output logic             idex_bubble,
   output logic             ifid_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
   } ex_stage_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       reg_write;
   } wr_stage_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   ex_stage_t        ex_q, ex_d;
   wr_stage_t        mem_q, mem_d;
   wr_stage_t        wb_q, wb_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic ex_wr, mem_wr, wb_wr;
   logic m_ex_rs, m_ex_rt, m_mem_rs, m_mem_rt;
   logic load_use, stall;

   // A write to $0 is architecturally a no-op, so it never creates a dependence.
   function automatic logic src_match(input logic used, input logic [4:0] src,
                                      input logic wr, input logic [4:0] rd);
      return used && wr && (rd == src);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input wr_stage_t mem, input logic mem_w,
                                          input wr_stage_t wb, input logic wb_w);
      logic [1:0] sel;
      sel = FWD_RF;
      if (mem_w && (mem.rd == src)) begin
         sel = FWD_MEM;
      end else if (wb_w && (wb.rd == src)) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

   always_comb begin
      ex_wr  = ex_q.reg_write && (ex_q.rd != '0);
      mem_wr = mem_q.reg_write && (mem_q.rd != '0);
      wb_wr  = wb_q.reg_write && (wb_q.rd != '0);

      m_ex_rs  = src_match(id_use_rs, id_rs, ex_wr, ex_q.rd);
      m_ex_rt  = src_match(id_use_rt, id_rt, ex_wr, ex_q.rd);
      m_mem_rs = src_match(id_use_rs, id_rs, mem_wr, mem_q.rd);
      m_mem_rt = src_match(id_use_rt, id_rt, mem_wr, mem_q.rd);

      load_use = ex_q.mem_read && (m_ex_rs || m_ex_rt);
      // Without forwarding, only WB is safe because the regfile writes through.
      stall    = bypass_en ? load_use : (m_ex_rs || m_ex_rt || m_mem_rs || m_mem_rt);
   end

   always_comb begin
      pc_hold     = 1'b0;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      fwd_a       = FWD_RF;
      fwd_b       = FWD_RF;
      if (!reset) begin
         // A taken branch squashes the stalled ID instruction, so it wins.
         if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if (stall) begin
            pc_hold     = 1'b1;
            idex_bubble = 1'b1;
         end
         if (bypass_en && ex_q.valid) begin
            fwd_a = fwd_sel(ex_q.rs, mem_q, mem_wr, wb_q, wb_wr);
            fwd_b = fwd_sel(ex_q.rt, mem_q, mem_wr, wb_q, wb_wr);
         end
      end
   end

   always_comb begin
      ex_d = '0;
      if (!idex_bubble) begin
         ex_d.valid     = 1'b1;
         ex_d.rs        = id_rs;
         ex_d.rt        = id_rt;
         ex_d.rd        = id_rd;
         ex_d.reg_write = id_reg_write && (id_rd != '0);
         ex_d.mem_read  = id_mem_read;
      end
      mem_d.rd        = ex_q.rd;
      mem_d.reg_write = ex_q.reg_write;
      wb_d            = mem_q;

      stall_cnt_d = stall_cnt_q;
      if (pc_hold && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      flush_cnt_d = flush_cnt_q;
      if (ifid_flush && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule
